// File: rtl/echo_requester.sv
// echo_requester: issues a burst of incrementing echo requests and checks returned indications in order.
// Outstanding payloads are held in a small FIFO; mismatches and response timeouts are reported.
module echo_requester #(
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             start__ENA,
    input  logic [CNT_W-1:0] start_count,
    input  logic [31:0]      start_seed,
    output logic             start__RDY,
    output logic             echoReq__ENA,
    output logic [31:0]      echoReq_v,
    input  logic             echoReq__RDY,
    input  logic             echo__ENA,
    input  logic [31:0]      echo_v,
    output logic             echo__RDY,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] errors,
    output logic [CNT_W-1:0] received
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [AW:0]   FULL = (AW + 1)'(DEPTH);
    localparam logic [TW-1:0] TMO  = TW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state, state_nx;

    logic [CNT_W-1:0] count, issued;
    logic [31:0]      next_v;
    logic [31:0]      mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      fcnt;
    logic [TW-1:0]    idle;
    logic             go, push, pop, full, empty, active, tmo;

    assign full         = fcnt == FULL;
    assign empty        = fcnt == '0;
    assign tmo          = idle == TMO;
    assign active       = state == RUN || state == DRAIN;
    assign start__RDY   = state == IDLE || state == DONE;
    assign go           = start__ENA && start__RDY;
    assign echoReq__ENA = state == RUN && issued < count && !full && echoReq__RDY;
    assign echoReq_v    = next_v;
    assign echo__RDY    = active && !empty;
    assign push         = echoReq__ENA;
    assign pop          = echo__ENA && echo__RDY;

    always_comb begin
        state_nx = state;
        if (go)
            state_nx = RUN;
        else if (active && tmo)
            state_nx = DONE;
        else if (state == RUN && issued == count)
            state_nx = DRAIN;
        else if (state == DRAIN && received == count)
            state_nx = DONE;
    end

    always_ff @(posedge CLK or negedge nRST)
        if (!nRST)
            state <= IDLE;
        else
            state <= state_nx;

    always_ff @(posedge CLK)
        if (push)
            mem[wr_ptr] <= next_v;

    always_ff @(posedge CLK or negedge nRST)
        if (!nRST) begin
            count    <= '0;
            issued   <= '0;
            received <= '0;
            errors   <= '0;
            next_v   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fcnt     <= '0;
            idle     <= '0;
            done     <= 1'b0;
            timeout  <= 1'b0;
        end else if (go) begin
            count    <= start_count;
            next_v   <= start_seed;
            issued   <= '0;
            received <= '0;
            errors   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fcnt     <= '0;
            idle     <= '0;
            done     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            if (push) begin
                next_v <= next_v + 32'd1;
                issued <= issued + 1'b1;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                received <= received + 1'b1;
                if (mem[rd_ptr] != echo_v && errors != '1)
                    errors <= errors + 1'b1;
            end
            fcnt <= fcnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            // Timer only runs while something is outstanding and nothing is coming back
            idle <= pop ? '0 : (active && !empty && !tmo) ? idle + 1'b1 : idle;
            if (active && state_nx == DONE) begin
                done    <= 1'b1;
                timeout <= tmo;
            end
        end
endmodule
